// File: rtl/p_output_stage.sv
// p_output_stage: P output register with pattern detect, overflow/underflow flags and auto-reset
module p_output_stage #(
  parameter int          PREG               = 1,
  parameter logic [47:0] PATTERN            = 48'h0,
  parameter logic [47:0] MASK               = 48'h3FFF_FFFF_FFFF,
  parameter int          SEL_PATTERN        = 0,
  parameter int          SEL_MASK           = 0,
  parameter int          USE_PATTERN_DETECT = 1,
  parameter int          AUTORESET_PATDET   = 0
) (
  input  logic        clk,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic [47:0] ALU_out,
  input  logic [47:0] C,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        PATTERNDETECT,
  output logic        PATTERNBDETECT,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);
  logic [47:0] pat, msk, p_q, p_d;
  logic pd_c, pbd_c, ar;
  logic pd_q, pd_d, pbd_q, pbd_d, pdp_q, pdp_d, pbdp_q, pbdp_d;
  assign pat   = (SEL_PATTERN != 0) ? C : PATTERN;
  assign msk   = (SEL_MASK != 0) ? C : MASK;
  assign pd_c  = &(~(ALU_out ^ pat) | msk);
  assign pbd_c = &((ALU_out ^ pat) | msk);
  assign ar = (AUTORESET_PATDET == 1) ? pd_q :
              (AUTORESET_PATDET == 2) ? (~pd_q & pdp_q) : 1'b0;
  // next state: load or auto-clear on enable, past-detect tracks the registered detect either way
  always_comb begin
    p_d    = p_q;
    pd_d   = pd_q;
    pbd_d  = pbd_q;
    pdp_d  = pdp_q;
    pbdp_d = pbdp_q;
    if (CEP) begin
      p_d    = ar ? '0 : ALU_out;
      pd_d   = ar ? 1'b0 : pd_c;
      pbd_d  = ar ? 1'b0 : pbd_c;
      pdp_d  = pd_q;
      pbdp_d = pbd_q;
    end
  end
  // state registers; held at zero when the P path is combinational
  always_ff @(posedge clk) begin
    if (RSTP || PREG == 0) begin
      p_q    <= '0;
      pd_q   <= 1'b0;
      pbd_q  <= 1'b0;
      pdp_q  <= 1'b0;
      pbdp_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      pd_q   <= pd_d;
      pbd_q  <= pbd_d;
      pdp_q  <= pdp_d;
      pbdp_q <= pbdp_d;
    end
  end
  assign P              = (PREG != 0) ? p_q : ALU_out;
  assign PCOUT          = P;
  assign PATTERNDETECT  = (USE_PATTERN_DETECT != 0) && ((PREG != 0) ? pd_q : pd_c);
  assign PATTERNBDETECT = (USE_PATTERN_DETECT != 0) && ((PREG != 0) ? pbd_q : pbd_c);
  assign OVERFLOW       = (USE_PATTERN_DETECT != 0) && (PREG != 0) && pdp_q && !pd_q && !pbd_q;
  assign UNDERFLOW      = (USE_PATTERN_DETECT != 0) && (PREG != 0) && pbdp_q && !pd_q && !pbd_q;
endmodule

// File: tb/tb_p_output_stage.sv
// tb_p_output_stage: directed scoreboard bench over several p_output_stage configurations
module tb_p_output_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstp, cep;
  logic [47:0] alu, c;
  logic [47:0] p_o [5];
  logic [47:0] pc_o [5];
  logic pd_o [5], pbd_o [5], of_o [5], uf_o [5];
  int total = 0, bad = 0;
  typedef struct {string tag; int id; logic [47:0] p; logic pd, pbd, of, uf;} exp_t;
  exp_t sb [$];

  p_output_stage u_main (.clk(clk), .RSTP(rstp), .CEP(cep), .ALU_out(alu), .C(c),
    .P(p_o[0]), .PCOUT(pc_o[0]), .PATTERNDETECT(pd_o[0]), .PATTERNBDETECT(pbd_o[0]),
    .OVERFLOW(of_o[0]), .UNDERFLOW(uf_o[0]));
  p_output_stage #(.AUTORESET_PATDET(1), .SEL_PATTERN(1), .MASK(48'h0)) u_ar1 (.clk(clk), .RSTP(rstp),
    .CEP(cep), .ALU_out(alu), .C(c), .P(p_o[1]), .PCOUT(pc_o[1]), .PATTERNDETECT(pd_o[1]),
    .PATTERNBDETECT(pbd_o[1]), .OVERFLOW(of_o[1]), .UNDERFLOW(uf_o[1]));
  p_output_stage #(.AUTORESET_PATDET(2)) u_ar2 (.clk(clk), .RSTP(rstp), .CEP(cep), .ALU_out(alu), .C(c),
    .P(p_o[2]), .PCOUT(pc_o[2]), .PATTERNDETECT(pd_o[2]), .PATTERNBDETECT(pbd_o[2]),
    .OVERFLOW(of_o[2]), .UNDERFLOW(uf_o[2]));
  p_output_stage #(.PREG(0)) u_comb (.clk(clk), .RSTP(rstp), .CEP(cep), .ALU_out(alu), .C(c),
    .P(p_o[3]), .PCOUT(pc_o[3]), .PATTERNDETECT(pd_o[3]), .PATTERNBDETECT(pbd_o[3]),
    .OVERFLOW(of_o[3]), .UNDERFLOW(uf_o[3]));
  p_output_stage #(.USE_PATTERN_DETECT(0)) u_nopd (.clk(clk), .RSTP(rstp), .CEP(cep), .ALU_out(alu), .C(c),
    .P(p_o[4]), .PCOUT(pc_o[4]), .PATTERNDETECT(pd_o[4]), .PATTERNBDETECT(pbd_o[4]),
    .OVERFLOW(of_o[4]), .UNDERFLOW(uf_o[4]));

  task automatic push(input string tag, input int id, input logic [47:0] p,
                      input logic pd, input logic pbd, input logic of, input logic uf);
    exp_t e;
    e.tag = tag; e.id = id; e.p = p; e.pd = pd; e.pbd = pbd; e.of = of; e.uf = uf;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [99:0] got, want;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got  = {p_o[e.id], pc_o[e.id], pd_o[e.id], pbd_o[e.id], of_o[e.id], uf_o[e.id]};
      want = {e.p, e.p, e.pd, e.pbd, e.of, e.uf};
      total++;
      assert (got === want) else begin
        bad++;
        $error("FAIL %s dut%0d: got P=%h PCOUT=%h pd=%b pbd=%b of=%b uf=%b want P=%h pd=%b pbd=%b of=%b uf=%b",
               e.tag, e.id, p_o[e.id], pc_o[e.id], pd_o[e.id], pbd_o[e.id], of_o[e.id], uf_o[e.id],
               e.p, e.pd, e.pbd, e.of, e.uf);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rstp = 1'b0; cep = 1'b0; alu = '0; c = '0;
    @(posedge clk); #1;
    rstp = 1'b1; cep = 1'b1; alu = 48'h123;
    push("reset", 0, 48'h0, 0, 0, 0, 0);
    push("reset_ar1", 1, 48'h0, 0, 0, 0, 0);
    push("reset_ar2", 2, 48'h0, 0, 0, 0, 0);
    step();
    rstp = 1'b0; alu = 48'hAB;
    push("load", 0, 48'hAB, 1, 0, 0, 0);
    push("load_nopd", 4, 48'hAB, 0, 0, 0, 0);
    step();
    cep = 1'b0; alu = 48'h5;
    push("hold", 0, 48'hAB, 1, 0, 0, 0);
    step();
    rstp = 1'b1; cep = 1'b1;
    push("rst2", 0, 48'h0, 0, 0, 0, 0);
    push("rst2_ar2", 2, 48'h0, 0, 0, 0, 0);
    step();
    rstp = 1'b0; alu = 48'h3FFF_FFFF_FFFF;
    push("ovf_a", 0, 48'h3FFF_FFFF_FFFF, 1, 0, 0, 0);
    push("ovf_a_ar2", 2, 48'h3FFF_FFFF_FFFF, 1, 0, 0, 0);
    step();
    alu = 48'h4000_0000_0000;
    push("ovf_b", 0, 48'h4000_0000_0000, 0, 0, 1, 0);
    push("ovf_b_ar2", 2, 48'h4000_0000_0000, 0, 0, 1, 0);
    step();
    push("ovf_hold", 0, 48'h4000_0000_0000, 0, 0, 0, 0);
    push("ar2_fall", 2, 48'h0, 0, 0, 0, 0);
    step();
    alu = 48'hC000_0000_0000;
    push("unf_a", 0, 48'hC000_0000_0000, 0, 1, 0, 0);
    step();
    alu = 48'hBFFF_FFFF_FFFF;
    push("unf_b", 0, 48'hBFFF_FFFF_FFFF, 0, 0, 0, 1);
    step();
    alu = 48'h3FFF_FFFF_FFFF;
    push("pre_rst", 0, 48'h3FFF_FFFF_FFFF, 1, 0, 0, 0);
    step();
    rstp = 1'b1;
    push("mid_rst", 0, 48'h0, 0, 0, 0, 0);
    step();
    rstp = 1'b0; alu = 48'h4000_0000_0000;
    push("post_rst_noovf", 0, 48'h4000_0000_0000, 0, 0, 0, 0);
    step();
    rstp = 1'b1;
    push("ar1_rst", 1, 48'h0, 0, 0, 0, 0);
    step();
    rstp = 1'b0; c = 48'h64; alu = 48'h64;
    push("ar1_e1", 1, 48'h64, 1, 0, 0, 0);
    step();
    push("ar1_e2", 1, 48'h0, 0, 0, 1, 0);
    step();
    push("ar1_e3", 1, 48'h64, 1, 0, 0, 0);
    step();
    cep = 1'b0;
    push("ar1_cep0", 1, 48'h64, 1, 0, 0, 0);
    step();
    cep = 1'b1;
    push("ar1_pending", 1, 48'h0, 0, 0, 1, 0);
    step();
    alu = 48'h7;
    #1;
    push("comb", 3, 48'h7, 1, 0, 0, 0);
    drain();
    rstp = 1'b1;
    push("comb_rst", 3, 48'h7, 1, 0, 0, 0);
    step();
    rstp = 1'b0; alu = 48'hC000_0000_0000;
    #1;
    push("comb_pbd", 3, 48'hC000_0000_0000, 0, 1, 0, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
